// File: rtl/reorder_buffer.sv
// In-order reorder buffer: allocates at the tail, accepts out-of-order results, and
// retires one entry per cycle from the head, redirecting fetch on mispredicts and JALR.
module reorder_buffer #(
    parameter int RoB_WIDTH = 4,
    parameter int NON_DEP   = 1 << RoB_WIDTH
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 alloc_en,
    input  logic [1:0]           alloc_type,
    input  logic [4:0]           alloc_rd,
    input  logic [31:0]          alloc_pc,
    input  logic [31:0]          alloc_target,
    input  logic                 alloc_pred_taken,
    output logic [RoB_WIDTH-1:0] alloc_index,
    output logic                 isFull,
    output logic                 isEmpty,
    input  logic                 RS_update_en,
    input  logic [RoB_WIDTH-1:0] RS_update_index,
    input  logic [31:0]          RS_update_data,
    input  logic                 CDB_update_en,
    input  logic [RoB_WIDTH-1:0] CDB_update_index,
    input  logic [31:0]          CDB_update_data,
    input  logic [RoB_WIDTH-1:0] query_index,
    output logic                 query_ready,
    output logic [31:0]          query_data,
    output logic                 commit_reg_en,
    output logic [4:0]           commit_rd,
    output logic [31:0]          commit_data,
    output logic [RoB_WIDTH-1:0] commit_index,
    output logic                 commit_store_en,
    output logic                 flush_signal,
    output logic [31:0]          flush_pc
);
    localparam int RoB_SIZE = 1 << RoB_WIDTH;
    localparam int CNT_W    = RoB_WIDTH + 1;
    // The "no dependency" tag is one past the last index, i.e. the entry count when full.
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NON_DEP);

    typedef enum logic [1:0] {
        TYPE_REG    = 2'd0,
        TYPE_BRANCH = 2'd1,
        TYPE_STORE  = 2'd2,
        TYPE_JALR   = 2'd3
    } rob_type_e;

    logic                 busy_q   [RoB_SIZE];
    logic                 ready_q  [RoB_SIZE];
    rob_type_e            type_q   [RoB_SIZE];
    logic [4:0]           rd_q     [RoB_SIZE];
    logic [31:0]          pc_q     [RoB_SIZE];
    logic [31:0]          target_q [RoB_SIZE];
    logic                 pred_q   [RoB_SIZE];
    logic [31:0]          data_q   [RoB_SIZE];

    logic [RoB_WIDTH-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]     count_q, count_d;

    logic                 commit_reg_en_q, commit_store_en_q, flush_signal_q;
    logic [4:0]           commit_rd_q;
    logic [31:0]          commit_data_q, flush_pc_q;
    logic [RoB_WIDTH-1:0] commit_index_q;

    logic                 do_alloc, do_commit, do_flush, mispredict;
    logic                 rs_hit, cdb_hit;
    rob_type_e            head_type;
    logic [4:0]           head_rd;
    logic [31:0]          head_pc, head_target, head_data;

    assign isFull      = (count_q == FULL_CNT);
    assign isEmpty     = (count_q == '0);
    assign alloc_index = tail_q;
    assign query_ready = busy_q[query_index] && ready_q[query_index];
    assign query_data  = data_q[query_index];

    // Alloc handshake: alloc_en is the request; it is taken at the edge only when the
    // buffer is not full and no redirect is in flight, and lands at alloc_index.
    always_comb begin
        head_type   = type_q[head_q];
        head_rd     = rd_q[head_q];
        head_pc     = pc_q[head_q];
        head_target = target_q[head_q];
        head_data   = data_q[head_q];
        do_alloc    = rdy_in && !flush_signal_q && alloc_en && !isFull;
        do_commit   = rdy_in && !flush_signal_q && busy_q[head_q] && ready_q[head_q];
        mispredict  = (head_type == TYPE_BRANCH) && (head_data[0] != pred_q[head_q]);
        do_flush    = do_commit && (mispredict || head_type == TYPE_JALR);
        rs_hit      = rdy_in && !flush_signal_q && RS_update_en && busy_q[RS_update_index];
        cdb_hit     = rdy_in && !flush_signal_q && CDB_update_en && busy_q[CDB_update_index]
                      && !(rs_hit && RS_update_index == CDB_update_index);
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        if (do_flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (do_alloc)  tail_d = tail_q + RoB_WIDTH'(1);
            if (do_commit) head_d = head_q + RoB_WIDTH'(1);
            case ({do_alloc, do_commit})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < RoB_SIZE; i++) begin
                busy_q[i]  <= 1'b0;
                ready_q[i] <= 1'b0;
            end
        end else if (do_flush) begin
            for (int i = 0; i < RoB_SIZE; i++) begin
                busy_q[i]  <= 1'b0;
                ready_q[i] <= 1'b0;
            end
        end else begin
            if (cdb_hit) ready_q[CDB_update_index] <= 1'b1;
            if (rs_hit)  ready_q[RS_update_index]  <= 1'b1;
            if (do_alloc) begin
                busy_q[tail_q]  <= 1'b1;
                // Stores carry no result, so they are retire-ready from the start.
                ready_q[tail_q] <= (rob_type_e'(alloc_type) == TYPE_STORE);
            end
            if (do_commit) begin
                busy_q[head_q]  <= 1'b0;
                ready_q[head_q] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (cdb_hit) data_q[CDB_update_index] <= CDB_update_data;
        if (rs_hit)  data_q[RS_update_index]  <= RS_update_data;
        if (do_alloc) begin
            type_q[tail_q]   <= rob_type_e'(alloc_type);
            rd_q[tail_q]     <= alloc_rd;
            pc_q[tail_q]     <= alloc_pc;
            target_q[tail_q] <= alloc_target;
            pred_q[tail_q]   <= alloc_pred_taken;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            commit_reg_en_q   <= 1'b0;
            commit_store_en_q <= 1'b0;
            flush_signal_q    <= 1'b0;
            commit_rd_q       <= '0;
            commit_data_q     <= '0;
            commit_index_q    <= '0;
            flush_pc_q        <= '0;
        end else begin
            commit_reg_en_q   <= 1'b0;
            commit_store_en_q <= 1'b0;
            flush_signal_q    <= 1'b0;
            commit_rd_q       <= '0;
            commit_data_q     <= '0;
            commit_index_q    <= '0;
            if (do_commit) begin
                commit_index_q <= head_q;
                case (head_type)
                    TYPE_REG: begin
                        commit_reg_en_q <= (head_rd != 5'd0);
                        commit_rd_q     <= head_rd;
                        commit_data_q   <= head_data;
                    end
                    TYPE_STORE: commit_store_en_q <= 1'b1;
                    TYPE_BRANCH: begin
                        if (mispredict) begin
                            flush_signal_q <= 1'b1;
                            flush_pc_q     <= head_data[0] ? head_target : head_pc + 32'd4;
                        end
                    end
                    TYPE_JALR: begin
                        commit_reg_en_q <= (head_rd != 5'd0);
                        commit_rd_q     <= head_rd;
                        commit_data_q   <= head_pc + 32'd4;
                        flush_signal_q  <= 1'b1;
                        flush_pc_q      <= head_data;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign commit_reg_en   = commit_reg_en_q;
    assign commit_store_en = commit_store_en_q;
    assign flush_signal    = flush_signal_q;
    assign commit_rd       = commit_rd_q;
    assign commit_data     = commit_data_q;
    assign commit_index    = commit_index_q;
    assign flush_pc        = flush_pc_q;
endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: scenario tasks with inline checks plus a commit scoreboard
// fed with expected retirements and drained by a negedge monitor.
module tb_reorder_buffer;
    localparam int EW = 76;
    localparam logic [1:0] T_REG = 2'd0, T_BRANCH = 2'd1, T_STORE = 2'd2, T_JALR = 2'd3;

    logic        clk_in, rst_in, rdy_in;
    logic        alloc_en, alloc_pred_taken;
    logic [1:0]  alloc_type;
    logic [4:0]  alloc_rd;
    logic [31:0] alloc_pc, alloc_target;
    logic [3:0]  alloc_index;
    logic        isFull, isEmpty;
    logic        RS_update_en, CDB_update_en;
    logic [3:0]  RS_update_index, CDB_update_index, query_index;
    logic [31:0] RS_update_data, CDB_update_data, query_data;
    logic        query_ready;
    logic        commit_reg_en, commit_store_en, flush_signal;
    logic [4:0]  commit_rd;
    logic [31:0] commit_data, flush_pc;
    logic [3:0]  commit_index;

    int checks = 0;
    int errors = 0;
    // {reg_en, store_en, flush, rd[4:0], data[31:0], index[3:0], flush_pc[31:0]}
    logic [EW-1:0] exp_q[$];

    reorder_buffer dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .alloc_en(alloc_en), .alloc_type(alloc_type), .alloc_rd(alloc_rd),
        .alloc_pc(alloc_pc), .alloc_target(alloc_target), .alloc_pred_taken(alloc_pred_taken),
        .alloc_index(alloc_index), .isFull(isFull), .isEmpty(isEmpty),
        .RS_update_en(RS_update_en), .RS_update_index(RS_update_index), .RS_update_data(RS_update_data),
        .CDB_update_en(CDB_update_en), .CDB_update_index(CDB_update_index), .CDB_update_data(CDB_update_data),
        .query_index(query_index), .query_ready(query_ready), .query_data(query_data),
        .commit_reg_en(commit_reg_en), .commit_rd(commit_rd), .commit_data(commit_data),
        .commit_index(commit_index), .commit_store_en(commit_store_en),
        .flush_signal(flush_signal), .flush_pc(flush_pc)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    function automatic logic [EW-1:0] mk_exp(input logic reg_en, input logic store_en, input logic flush,
                                             input logic [4:0] rd, input logic [31:0] data,
                                             input logic [3:0] idx, input logic [31:0] fpc);
        return {reg_en, store_en, flush, rd, data, idx, fpc};
    endfunction

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic hard_reset();
        rst_in = 1'b1; rdy_in = 1'b1;
        alloc_en = 1'b0; alloc_type = T_REG; alloc_rd = '0; alloc_pc = '0;
        alloc_target = '0; alloc_pred_taken = 1'b0;
        RS_update_en = 1'b0; RS_update_index = '0; RS_update_data = '0;
        CDB_update_en = 1'b0; CDB_update_index = '0; CDB_update_data = '0;
        query_index = '0;
        exp_q.delete();
        repeat (2) @(posedge clk_in);
        #1;
        rst_in = 1'b0;
    endtask

    task automatic alloc(input logic [1:0] t, input logic [4:0] rd, input logic [31:0] pc,
                         input logic [31:0] tgt, input logic pred);
        alloc_en = 1'b1; alloc_type = t; alloc_rd = rd; alloc_pc = pc;
        alloc_target = tgt; alloc_pred_taken = pred;
        step();
        alloc_en = 1'b0;
    endtask

    task automatic rs_wb(input logic [3:0] idx, input logic [31:0] d);
        RS_update_en = 1'b1; RS_update_index = idx; RS_update_data = d;
        step();
        RS_update_en = 1'b0;
    endtask

    task automatic cdb_wb(input logic [3:0] idx, input logic [31:0] d);
        CDB_update_en = 1'b1; CDB_update_index = idx; CDB_update_data = d;
        step();
        CDB_update_en = 1'b0;
    endtask

    task automatic commit_monitor();
        logic [EW-1:0] e;
        forever begin
            @(negedge clk_in);
            if (!rst_in && (commit_reg_en || commit_store_en || flush_signal)) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_commit: got reg_en=%0b store_en=%0b flush=%0b index=%0d, required no commit",
                             commit_reg_en, commit_store_en, flush_signal, commit_index);
                end else begin
                    e = exp_q.pop_front();
                    if ({commit_reg_en, commit_store_en, flush_signal, commit_index} !== {e[75:73], e[35:32]}) begin
                        errors++;
                        $display("FAIL commit_kind: got en/st/fl=%b index=%0d, required %b index=%0d",
                                 {commit_reg_en, commit_store_en, flush_signal}, commit_index, e[75:73], e[35:32]);
                    end
                    if (e[75]) begin
                        checks++;
                        if ({commit_rd, commit_data} !== e[72:36]) begin
                            errors++;
                            $display("FAIL commit_reg: got rd=%0d data=%h, required rd=%0d data=%h",
                                     commit_rd, commit_data, e[72:68], e[67:36]);
                        end
                    end
                    if (e[73]) begin
                        checks++;
                        if (flush_pc !== e[31:0]) begin
                            errors++;
                            $display("FAIL flush_pc: got %h, required %h", flush_pc, e[31:0]);
                        end
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        hard_reset();
        checks++;
        if ({isEmpty, isFull, alloc_index} !== {1'b1, 1'b0, 4'd0}) begin
            errors++;
            $display("FAIL reset_state: got empty=%0b full=%0b alloc_index=%0d, required 1 0 0", isEmpty, isFull, alloc_index);
        end
        for (int i = 0; i < 6; i++) alloc(T_REG, 5'(i + 1), 32'(i * 4), '0, 1'b0);
        exp_q.push_back(mk_exp(1'b1, 1'b0, 1'b0, 5'd1, 32'h55, 4'd0, '0));
        rs_wb(4'd0, 32'h55);
        @(posedge clk_in);
        #6;
        checks++;
        if ({commit_reg_en, isEmpty, alloc_index} !== {1'b1, 1'b0, 4'd6}) begin
            errors++;
            $display("FAIL reset_precond: got reg_en=%0b empty=%0b alloc_index=%0d, required 1 0 6", commit_reg_en, isEmpty, alloc_index);
        end
        rst_in = 1'b1;
        #1;
        checks++;
        if ({isEmpty, alloc_index} !== {1'b1, 4'd0}) begin
            errors++;
            $display("FAIL reset_async_state: got empty=%0b alloc_index=%0d, required 1 0", isEmpty, alloc_index);
        end
        checks++;
        if ({commit_reg_en, commit_store_en, flush_signal, commit_rd, commit_index, commit_data, flush_pc} !== '0) begin
            errors++;
            $display("FAIL reset_async_outputs: got reg_en=%0b rd=%0d data=%h index=%0d flush=%0b, required all 0",
                     commit_reg_en, commit_rd, commit_data, commit_index, flush_signal);
        end
        @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_reset: %0d commits pending, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reg_commit();
        hard_reset();
        alloc(T_REG, 5'd3, 32'h0, '0, 1'b0);
        query_index = 4'd0;
        #0;
        checks++;
        if (query_ready !== 1'b0) begin
            errors++;
            $display("FAIL query_before_wb: got ready=%0b, required 0", query_ready);
        end
        exp_q.push_back(mk_exp(1'b1, 1'b0, 1'b0, 5'd3, 32'h1234, 4'd0, '0));
        rs_wb(4'd0, 32'h1234);
        checks++;
        if ({query_ready, query_data} !== {1'b1, 32'h1234}) begin
            errors++;
            $display("FAIL query_after_wb: got ready=%0b data=%h, required 1 00001234", query_ready, query_data);
        end
        repeat (2) step();
        checks++;
        if (isEmpty !== 1'b1 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_reg_commit: got empty=%0b pending=%0d, required 1 0", isEmpty, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_in_order();
        hard_reset();
        alloc(T_REG, 5'd5, 32'h0, '0, 1'b0);
        alloc(T_REG, 5'd6, 32'h4, '0, 1'b0);
        exp_q.push_back(mk_exp(1'b1, 1'b0, 1'b0, 5'd5, 32'hAAAA, 4'd0, '0));
        exp_q.push_back(mk_exp(1'b1, 1'b0, 1'b0, 5'd6, 32'hBBBB, 4'd1, '0));
        rs_wb(4'd1, 32'hBBBB);
        repeat (2) step();
        checks++;
        if (exp_q.size() != 2) begin
            errors++;
            $display("FAIL in_order_hold: got %0d pending, required 2 (younger must wait)", exp_q.size());
        end
        rs_wb(4'd0, 32'hAAAA);
        step();
        checks++;
        if ({commit_reg_en, commit_index} !== {1'b1, 4'd0}) begin
            errors++;
            $display("FAIL in_order_first: got reg_en=%0b index=%0d, required 1 0", commit_reg_en, commit_index);
        end
        step();
        checks++;
        if ({commit_reg_en, commit_index} !== {1'b1, 4'd1}) begin
            errors++;
            $display("FAIL in_order_second: got reg_en=%0b index=%0d, required 1 1", commit_reg_en, commit_index);
        end
        alloc(T_REG, 5'd0, 32'h8, '0, 1'b0);
        rs_wb(4'd2, 32'h99);
        step();
        checks++;
        if ({commit_reg_en, commit_index, isEmpty} !== {1'b0, 4'd2, 1'b1}) begin
            errors++;
            $display("FAIL rd0_commit: got reg_en=%0b index=%0d empty=%0b, required 0 2 1", commit_reg_en, commit_index, isEmpty);
        end
        step();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_in_order: %0d commits pending, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_full_wrap();
        logic [31:0] d;
        hard_reset();
        for (int i = 0; i < 16; i++) begin
            alloc(T_REG, 5'(i + 1), 32'(i * 4), '0, 1'b0);
            checks++;
            if (alloc_index !== 4'(i + 1)) begin
                errors++;
                $display("FAIL fill_index: got %0d, required %0d", alloc_index, 4'(i + 1));
            end
        end
        alloc(T_REG, 5'd31, 32'hFC, '0, 1'b0);
        checks++;
        if ({isFull, isEmpty, alloc_index} !== {1'b1, 1'b0, 4'd0}) begin
            errors++;
            $display("FAIL full_block: got full=%0b empty=%0b alloc_index=%0d, required 1 0 0", isFull, isEmpty, alloc_index);
        end
        exp_q.push_back(mk_exp(1'b1, 1'b0, 1'b0, 5'd1, 32'hC0, 4'd0, '0));
        rs_wb(4'd0, 32'hC0);
        alloc(T_REG, 5'd7, 32'h200, '0, 1'b0);
        checks++;
        if ({isFull, alloc_index} !== {1'b0, 4'd0}) begin
            errors++;
            $display("FAIL full_commit_same_cycle: got full=%0b alloc_index=%0d, required 0 0", isFull, alloc_index);
        end
        alloc(T_REG, 5'd7, 32'h200, '0, 1'b0);
        checks++;
        if ({isFull, alloc_index} !== {1'b1, 4'd1}) begin
            errors++;
            $display("FAIL wrap_alloc: got full=%0b alloc_index=%0d, required 1 1", isFull, alloc_index);
        end
        for (int j = 1; j < 16; j++) begin
            d = $urandom;
            exp_q.push_back(mk_exp(1'b1, 1'b0, 1'b0, 5'(j + 1), d, 4'(j), '0));
            if (j % 2 == 1) rs_wb(4'(j), d);
            else cdb_wb(4'(j), d);
        end
        exp_q.push_back(mk_exp(1'b1, 1'b0, 1'b0, 5'd7, 32'hD0, 4'd0, '0));
        cdb_wb(4'd0, 32'hD0);
        repeat (3) step();
        checks++;
        if (isEmpty !== 1'b1 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_full_wrap: got empty=%0b pending=%0d, required 1 0", isEmpty, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_branch();
        hard_reset();
        alloc(T_BRANCH, 5'd0, 32'h100, 32'h200, 1'b0);
        alloc(T_REG, 5'd9, 32'h104, '0, 1'b0);
        rs_wb(4'd1, 32'h1);
        exp_q.push_back(mk_exp(1'b0, 1'b0, 1'b1, 5'd0, '0, 4'd0, 32'h200));
        rs_wb(4'd0, 32'h1);
        step();
        checks++;
        if ({flush_signal, flush_pc, isEmpty, alloc_index} !== {1'b1, 32'h200, 1'b1, 4'd0}) begin
            errors++;
            $display("FAIL branch_flush: got flush=%0b pc=%h empty=%0b alloc_index=%0d, required 1 00000200 1 0",
                     flush_signal, flush_pc, isEmpty, alloc_index);
        end
        alloc(T_REG, 5'd10, 32'h200, '0, 1'b0);
        checks++;
        if ({flush_signal, isEmpty, alloc_index} !== {1'b0, 1'b1, 4'd0}) begin
            errors++;
            $display("FAIL flush_one_cycle: got flush=%0b empty=%0b alloc_index=%0d, required 0 1 0", flush_signal, isEmpty, alloc_index);
        end
        alloc(T_BRANCH, 5'd0, 32'h100, 32'h200, 1'b0);
        rs_wb(4'd0, 32'h0);
        step();
        checks++;
        if ({flush_signal, isEmpty} !== {1'b0, 1'b1}) begin
            errors++;
            $display("FAIL branch_correct: got flush=%0b empty=%0b, required 0 1", flush_signal, isEmpty);
        end
        alloc(T_BRANCH, 5'd0, 32'h300, 32'h400, 1'b1);
        exp_q.push_back(mk_exp(1'b0, 1'b0, 1'b1, 5'd0, '0, 4'd1, 32'h304));
        rs_wb(4'd1, 32'h0);
        step();
        checks++;
        if ({flush_signal, flush_pc} !== {1'b1, 32'h304}) begin
            errors++;
            $display("FAIL branch_not_taken_flush: got flush=%0b pc=%h, required 1 00000304", flush_signal, flush_pc);
        end
        repeat (3) step();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_branch: %0d commits pending, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_jalr();
        hard_reset();
        alloc(T_JALR, 5'd1, 32'h40, '0, 1'b0);
        exp_q.push_back(mk_exp(1'b1, 1'b0, 1'b1, 5'd1, 32'h44, 4'd0, 32'h80));
        rs_wb(4'd0, 32'h80);
        step();
        checks++;
        if ({flush_signal, commit_data, isEmpty} !== {1'b1, 32'h44, 1'b1}) begin
            errors++;
            $display("FAIL jalr_commit: got flush=%0b data=%h empty=%0b, required 1 00000044 1", flush_signal, commit_data, isEmpty);
        end
        repeat (2) step();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_jalr: %0d commits pending, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_wb_conflict();
        hard_reset();
        alloc(T_REG, 5'd2, 32'h0, '0, 1'b0);
        alloc(T_REG, 5'd4, 32'h4, '0, 1'b0);
        exp_q.push_back(mk_exp(1'b1, 1'b0, 1'b0, 5'd2, 32'hAAAA0001, 4'd0, '0));
        RS_update_en = 1'b1; RS_update_index = 4'd0; RS_update_data = 32'hAAAA0001;
        CDB_update_en = 1'b1; CDB_update_index = 4'd0; CDB_update_data = 32'h55550002;
        step();
        RS_update_en = 1'b0; CDB_update_en = 1'b0;
        query_index = 4'd0;
        #0;
        checks++;
        if ({query_ready, query_data} !== {1'b1, 32'hAAAA0001}) begin
            errors++;
            $display("FAIL rs_wins: got ready=%0b data=%h, required 1 aaaa0001", query_ready, query_data);
        end
        exp_q.push_back(mk_exp(1'b1, 1'b0, 1'b0, 5'd4, 32'h0C0FFEE0, 4'd1, '0));
        cdb_wb(4'd1, 32'h0C0FFEE0);
        alloc(T_REG, 5'd6, 32'h8, '0, 1'b0);
        alloc(T_REG, 5'd7, 32'hC, '0, 1'b0);
        exp_q.push_back(mk_exp(1'b1, 1'b0, 1'b0, 5'd6, 32'h22, 4'd2, '0));
        exp_q.push_back(mk_exp(1'b1, 1'b0, 1'b0, 5'd7, 32'h33, 4'd3, '0));
        RS_update_en = 1'b1; RS_update_index = 4'd3; RS_update_data = 32'h33;
        CDB_update_en = 1'b1; CDB_update_index = 4'd2; CDB_update_data = 32'h22;
        step();
        RS_update_en = 1'b0; CDB_update_en = 1'b0;
        repeat (3) step();
        checks++;
        if (isEmpty !== 1'b1 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_wb_conflict: got empty=%0b pending=%0d, required 1 0", isEmpty, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_store_rdy();
        hard_reset();
        exp_q.push_back(mk_exp(1'b0, 1'b1, 1'b0, 5'd0, '0, 4'd0, '0));
        alloc(T_STORE, 5'd0, 32'h10, '0, 1'b0);
        step();
        checks++;
        if ({commit_store_en, commit_reg_en} !== 2'b10) begin
            errors++;
            $display("FAIL store_commit: got store_en=%0b reg_en=%0b, required 1 0", commit_store_en, commit_reg_en);
        end
        alloc(T_REG, 5'd8, 32'h14, '0, 1'b0);
        rdy_in = 1'b0;
        rs_wb(4'd1, 32'h77);
        alloc(T_REG, 5'd12, 32'h18, '0, 1'b0);
        query_index = 4'd1;
        #0;
        checks++;
        if ({query_ready, alloc_index} !== {1'b0, 4'd2}) begin
            errors++;
            $display("FAIL rdy_low_hold: got ready=%0b alloc_index=%0d, required 0 2", query_ready, alloc_index);
        end
        rdy_in = 1'b1;
        exp_q.push_back(mk_exp(1'b1, 1'b0, 1'b0, 5'd8, 32'h88, 4'd1, '0));
        rs_wb(4'd1, 32'h88);
        step();
        exp_q.push_back(mk_exp(1'b1, 1'b0, 1'b0, 5'd11, 32'h11, 4'd2, '0));
        alloc(T_REG, 5'd11, 32'h1C, '0, 1'b0);
        rs_wb(4'd2, 32'h11);
        rdy_in = 1'b0;
        repeat (2) step();
        checks++;
        if (commit_reg_en !== 1'b0 || exp_q.size() != 1) begin
            errors++;
            $display("FAIL rdy_low_no_commit: got reg_en=%0b pending=%0d, required 0 1", commit_reg_en, exp_q.size());
        end
        rdy_in = 1'b1;
        step();
        checks++;
        if ({commit_reg_en, commit_index} !== {1'b1, 4'd2}) begin
            errors++;
            $display("FAIL rdy_resume_commit: got reg_en=%0b index=%0d, required 1 2", commit_reg_en, commit_index);
        end
        repeat (2) step();
        checks++;
        if (isEmpty !== 1'b1 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_store_rdy: got empty=%0b pending=%0d, required 1 0", isEmpty, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0]  prev_rd, rd;
        logic [31:0] d;
        hard_reset();
        prev_rd = '0;
        for (int k = 0; k < 20; k++) begin
            rd = 5'($urandom_range(1, 31));
            alloc_en = 1'b1; alloc_type = T_REG; alloc_rd = rd; alloc_pc = 32'(k * 4);
            if (k > 0) begin
                d = $urandom;
                exp_q.push_back(mk_exp(1'b1, 1'b0, 1'b0, prev_rd, d, 4'(k - 1), '0));
                RS_update_en = 1'b1; RS_update_index = 4'(k - 1); RS_update_data = d;
            end
            step();
            alloc_en = 1'b0; RS_update_en = 1'b0;
            prev_rd = rd;
            checks++;
            if (alloc_index !== 4'(k + 1)) begin
                errors++;
                $display("FAIL b2b_index: got %0d, required %0d", alloc_index, 4'(k + 1));
            end
        end
        d = $urandom;
        exp_q.push_back(mk_exp(1'b1, 1'b0, 1'b0, prev_rd, d, 4'd3, '0));
        rs_wb(4'd3, d);
        repeat (3) step();
        checks++;
        if ({isEmpty, alloc_index} !== {1'b1, 4'd4} || exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_back_to_back: got empty=%0b alloc_index=%0d pending=%0d, required 1 4 0",
                     isEmpty, alloc_index, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        rst_in = 1'b1;
        fork
            commit_monitor();
        join_none
        test_reset();
        test_reg_commit();
        test_in_order();
        test_full_wrap();
        test_branch();
        test_jalr();
        test_wb_conflict();
        test_store_rdy();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- Circular in-order reorder buffer, 16 entries.
- Allocates one RoB index per cycle to the dispatcher.
- Accepts out-of-order results from the reservation station (RS_update_*) and from the load/store path (CDB_update_*).
- Commits one entry per cycle at the head: register writes, store release, branch/jalr resolution. It generates flush_signal/flush_pc to every execute unit on a redirect.

Parameters:
RoB_WIDTH, 4, index width; RoB_SIZE = 1 << RoB_WIDTH entries
NON_DEP, 1 << RoB_WIDTH, "no dependency" tag value used by dispatch/RS

Ports:
clk_in  input  1  clock, all state on rising edge
rst_in  input  1  reset, asynchronous, active-high
rdy_in  input  1  global enable; low = hold all state
alloc_en  input  1  dispatcher requests a new entry this cycle
alloc_type  input  2  0 REG, 1 BRANCH, 2 STORE, 3 JALR
alloc_rd  input  5  destination register (REG/JALR)
alloc_pc  input  32  instruction pc
alloc_target  input  32  branch taken target (BRANCH only)
alloc_pred_taken  input  1  predicted direction (BRANCH only)
alloc_index  output  RoB_WIDTH  index the next accepted alloc receives (= tail)
isFull  output  1  count == RoB_SIZE
isEmpty  output  1  count == 0
RS_update_en / RS_update_index / RS_update_data  input  1 / RoB_WIDTH / 32  RS result writeback
CDB_update_en / CDB_update_index / CDB_update_data  input  1 / RoB_WIDTH / 32  load/store writeback
query_index  input  RoB_WIDTH  operand lookup from dispatcher
query_ready  output  1  combinational: entry busy and result present
query_data  output  32  combinational: stored result of query_index
commit_reg_en  output  1  registered pulse: write regfile
commit_rd  output  5  destination of committed entry
commit_data  output  32  value written
commit_index  output  RoB_WIDTH  committed RoB index (regfile clears matching tag)
commit_store_en  output  1  registered pulse: LSB may perform store commit_index
flush_signal  output  1  registered one-cycle redirect pulse
flush_pc  output  32  fetch restart address, valid with flush_signal

Behaviour:
- Per-entry state: busy, ready, type, rd, pc, target, pred_taken, data. head, tail (RoB_WIDTH bits, wrap modulo RoB_SIZE), count (RoB_WIDTH+1 bits).
- Reset (asynchronous): head = tail = count = 0. All busy/ready = 0. All registered outputs = 0, flush_pc = 0.
- rdy_in low: no state change. Registered pulse outputs drop to 0.
- Alloc: accepted iff alloc_en && !isFull && !flush_signal. Writes the entry at tail (busy=1, ready=0), tail+1, count+1. Accepted even if a commit frees a slot the same cycle only when not full at sample time.
- STORE entries are allocated ready=1 (no writeback needed).
- Writeback: either port with a matching busy entry sets data and ready=1. Writeback to a non-busy index is ignored. Both ports on the same index in one cycle: RS port wins.
- Commit: the cycle the head entry is busy && ready, the next edge does all of:
  - clears busy/ready, head+1, count−1;
  - drives commit_index = head.
  - REG: commit_reg_en = (rd != 0), commit_rd = rd, commit_data = data.
  - STORE: commit_store_en = 1.
  - BRANCH: no reg write. If data[0] != pred_taken, flush_signal = 1 and flush_pc = data[0] ? target : pc+4.
  - JALR: commit_reg_en = (rd != 0), commit_data = pc+4, flush_signal = 1, flush_pc = data.
- Pulse outputs are 0 in every cycle without a commit.
- Flush: on the same edge that raises flush_signal, the buffer empties (head = tail = count = 0, all busy = 0). During the flush_signal=1 cycle, allocs, writebacks and commits are ignored. The pulse lasts exactly one cycle.
- Simultaneous alloc + commit: count unchanged, head and tail both advance.
- Count arithmetic never wraps: full blocks alloc, empty blocks commit.
- Latency: writeback at edge N → earliest commit pulse at edge N+1 if the entry is the head.

Test Plan:
- Reset mid-run with count=5 → isEmpty=1, alloc_index=0, all outputs 0 immediately (asynchronous, before the next edge).
- Alloc REG rd=3 at idx0; RS writeback idx0 data=0x1234 → next cycle commit_reg_en=1, commit_rd=3, commit_data=0x1234, commit_index=0.
- Alloc REG idx0, REG idx1; writeback idx1 first, then idx0 → commits in order idx0 then idx1 on consecutive cycles.
- 16 allocs with no writeback → isFull=1; 17th alloc ignored, alloc_index stays 0. Commit idx0 → alloc_index 0 accepted next; tail wraps.
- BRANCH pc=0x100, target=0x200, pred_taken=0, writeback data=1 → flush_signal=1 for one cycle, flush_pc=0x200, isEmpty=1 after. Same case with data=0 → no flush.
- JALR rd=1 pc=0x40, writeback 0x80 → commit_data=0x44, flush_pc=0x80. Same-cycle RS and CDB writeback to one idx → RS data kept.
